// File: rtl/ea_arb_seq.sv
// Arbiter and pass sequencer sharing one 16-bit EA adder/logic core between two requesters.
// Double-precision add/sub runs as a low pass and then a high pass, with the carry chained between them.
module ea_arb_seq #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic [2:0]  op0_i,
   input  logic [2:0]  op1_i,
   input  logic [31:0] a0_i,
   input  logic [31:0] b0_i,
   input  logic [31:0] a1_i,
   input  logic [31:0] b1_i,
   output logic        gnt0_o,
   output logic        gnt1_o,
   output logic        done0_o,
   output logic        done1_o,
   output logic [31:0] r_o,
   output logic        cf_o,
   output logic        vf_n_o,
   output logic        zf_o,
   output logic [15:0] ea_x_o,
   output logic [15:0] ea_y_o,
   output logic        ea_k_o,
   output logic        ea_l_o,
   output logic        ea_add_o,
   output logic        ea_cin_o,
   input  logic [15:0] ea_alu_i,
   input  logic        ea_cout_i,
   input  logic        ea_ovf_n_i
);

   // state   | meaning
   // S_IDLE  | no operation, arbitrate requests
   // S_EX_LO | core runs the low 16-bit pass, grant pulse to the owner
   // S_EX_HI | core runs the high pass of DADD/DSUB
   // S_RESP  | done pulse to the owner, arbitrate for the next operation
   typedef enum logic [1:0] {S_IDLE, S_EX_LO, S_EX_HI, S_RESP} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_ADDC = 3'b101;
   localparam logic [2:0] OP_DADD = 3'b110;
   localparam logic [2:0] OP_DSUB = 3'b111;

   state_t      state_q, state_d;
   logic        own_q, own_d;
   logic        last_q, last_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        carry_q, carry_d;
   logic [31:0] r_q, r_d;
   logic        cf_q, cf_d;
   logic        vf_n_q, vf_n_d;
   logic        zf_q, zf_d;
   logic [1:0]  cfr_q, cfr_d;

   logic        arb_sel;
   logic        accept;
   logic        is_dbl;
   logic        is_sub;
   logic        is_arith;
   logic        hi_pass;
   logic [15:0] b_half;

   always_comb begin
      if (req0_i && req1_i) arb_sel = RR_EN ? ~last_q : 1'b0;
      else                  arb_sel = req1_i;
      accept   = (req0_i || req1_i) && (state_q == S_IDLE || state_q == S_RESP);
      is_dbl   = (op_q == OP_DADD) || (op_q == OP_DSUB);
      is_sub   = (op_q == OP_SUB) || (op_q == OP_DSUB);
      is_arith = !((op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR));
      hi_pass  = (state_q == S_EX_HI);
      b_half   = hi_pass ? b_q[31:16] : b_q[15:0];
   end

   always_comb begin
      ea_x_o   = '0;
      ea_y_o   = '0;
      ea_k_o   = 1'b0;
      ea_l_o   = 1'b0;
      ea_add_o = 1'b0;
      ea_cin_o = 1'b0;
      if (state_q == S_EX_LO || state_q == S_EX_HI) begin
         ea_x_o = hi_pass ? a_q[31:16] : a_q[15:0];
         ea_y_o = is_sub ? ~b_half : b_half;
         case (op_q)
            OP_AND: ;
            OP_OR:  ea_l_o = 1'b1;
            OP_XOR: begin
               ea_k_o = 1'b1;
               ea_l_o = 1'b1;
            end
            default: begin
               ea_k_o   = 1'b1;
               ea_l_o   = 1'b1;
               ea_add_o = 1'b1;
            end
         endcase
         if (hi_pass)               ea_cin_o = carry_q;
         else if (is_sub)           ea_cin_o = 1'b1;
         else if (op_q == OP_ADDC)  ea_cin_o = cfr_q[own_q];
      end
   end

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      r_d     = r_q;
      cf_d    = cf_q;
      vf_n_d  = vf_n_q;
      zf_d    = zf_q;
      cfr_d   = cfr_q;

      if (accept) begin
         own_d  = arb_sel;
         last_d = arb_sel;
         op_d   = arb_sel ? op1_i : op0_i;
         a_d    = arb_sel ? a1_i : a0_i;
         b_d    = arb_sel ? b1_i : b0_i;
      end

      case (state_q)
         S_IDLE: if (accept) state_d = S_EX_LO;
         S_EX_LO: begin
            if (is_dbl) begin
               r_d[15:0] = ea_alu_i;
               carry_d   = ea_cout_i;
               state_d   = S_EX_HI;
            end else begin
               r_d  = {16'h0000, ea_alu_i};
               zf_d = (ea_alu_i == 16'h0000);
               if (is_arith) begin
                  cf_d         = ea_cout_i;
                  vf_n_d       = ea_ovf_n_i;
                  cfr_d[own_q] = ea_cout_i;
               end else begin
                  vf_n_d = 1'b1;
               end
               state_d = S_RESP;
            end
         end
         S_EX_HI: begin
            // Flags of a double op describe the full 32-bit result.
            r_d[31:16]   = ea_alu_i;
            cf_d         = ea_cout_i;
            vf_n_d       = ea_ovf_n_i;
            cfr_d[own_q] = ea_cout_i;
            zf_d         = (ea_alu_i == 16'h0000) && (r_q[15:0] == 16'h0000);
            state_d      = S_RESP;
         end
         S_RESP: state_d = accept ? S_EX_LO : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         own_q   <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         r_q     <= '0;
         cf_q    <= 1'b0;
         vf_n_q  <= 1'b1;
         zf_q    <= 1'b0;
         cfr_q   <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         r_q     <= r_d;
         cf_q    <= cf_d;
         vf_n_q  <= vf_n_d;
         zf_q    <= zf_d;
         cfr_q   <= cfr_d;
      end
   end

   assign gnt0_o  = (state_q == S_EX_LO) && !own_q;
   assign gnt1_o  = (state_q == S_EX_LO) && own_q;
   assign done0_o = (state_q == S_RESP) && !own_q;
   assign done1_o = (state_q == S_RESP) && own_q;
   assign r_o     = r_q;
   assign cf_o    = cf_q;
   assign vf_n_o  = vf_n_q;
   assign zf_o    = zf_q;

endmodule

// File: tb/tb_ea_arb_seq.sv
// Bench for ea_arb_seq: behavioural EA core, arithmetic reference model, directed and random scenarios.
module tb_ea_arb_seq;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_ADDC = 3'b101;
   localparam logic [2:0] OP_DADD = 3'b110;
   localparam logic [2:0] OP_DSUB = 3'b111;
   localparam longint MAX32 = 64'sh0000_0000_7FFF_FFFF;
   localparam longint MIN32 = -MAX32 - 64'sd1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [2:0]  op0 = '0, op1 = '0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

   logic        gnt0, gnt1, done0, done1, cf, vf_n, zf;
   logic [31:0] r;
   logic [15:0] ea_x, ea_y, ea_alu;
   logic        ea_k, ea_l, ea_add, ea_cin, ea_cout, ea_ovf_n;

   logic        f_gnt0, f_gnt1, f_done0, f_done1, f_cf, f_vf_n, f_zf;
   logic [31:0] f_r;
   logic [15:0] f_ea_x, f_ea_y, f_ea_alu;
   logic        f_ea_k, f_ea_l, f_ea_add, f_ea_cin, f_ea_cout, f_ea_ovf_n;

   int          checks = 0;
   int          failures = 0;
   logic [1:0]  cf_ref;
   logic        cf_g;

   always #5 clk = ~clk;

   // EA core: adder when ADD=1, else AND/OR/XOR selected by K/L.
   function automatic logic [17:0] core(input logic [15:0] x, input logic [15:0] y,
                                        input logic k, input logic l, input logic add,
                                        input logic cin);
      logic [16:0] s;
      logic        ov;
      logic [15:0] q;
      if (add) begin
         s  = {1'b0, x} + {1'b0, y} + {16'h0000, cin};
         ov = (x[15] == y[15]) && (s[15] != x[15]);
         return {~ov, s};
      end
      if (!k && !l)     q = x & y;
      else if (!k && l) q = x | y;
      else              q = x ^ y;
      return {1'b1, 1'b0, q};
   endfunction

   assign {ea_ovf_n, ea_cout, ea_alu}       = core(ea_x, ea_y, ea_k, ea_l, ea_add, ea_cin);
   assign {f_ea_ovf_n, f_ea_cout, f_ea_alu} = core(f_ea_x, f_ea_y, f_ea_k, f_ea_l, f_ea_add, f_ea_cin);

   ea_arb_seq #(.RR_EN(1'b1)) dut (
      .clk_i(clk), .reset_i(rst), .req0_i(req0), .req1_i(req1), .op0_i(op0), .op1_i(op1),
      .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
      .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
      .r_o(r), .cf_o(cf), .vf_n_o(vf_n), .zf_o(zf),
      .ea_x_o(ea_x), .ea_y_o(ea_y), .ea_k_o(ea_k), .ea_l_o(ea_l), .ea_add_o(ea_add),
      .ea_cin_o(ea_cin), .ea_alu_i(ea_alu), .ea_cout_i(ea_cout), .ea_ovf_n_i(ea_ovf_n)
   );

   ea_arb_seq #(.RR_EN(1'b0)) dut_fp (
      .clk_i(clk), .reset_i(rst), .req0_i(req0), .req1_i(req1), .op0_i(op0), .op1_i(op1),
      .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
      .gnt0_o(f_gnt0), .gnt1_o(f_gnt1), .done0_o(f_done0), .done1_o(f_done1),
      .r_o(f_r), .cf_o(f_cf), .vf_n_o(f_vf_n), .zf_o(f_zf),
      .ea_x_o(f_ea_x), .ea_y_o(f_ea_y), .ea_k_o(f_ea_k), .ea_l_o(f_ea_l), .ea_add_o(f_ea_add),
      .ea_cin_o(f_ea_cin), .ea_alu_i(f_ea_alu), .ea_cout_i(f_ea_cout), .ea_ovf_n_i(f_ea_ovf_n)
   );

   // Reference: plain integer arithmetic on the whole operand width.
   task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic cfg,
                         output logic [31:0] rr, output logic [2:0] fl, output logic arith);
      longint ua, ub, ures, sa, sb, sres;
      logic   ov;
      arith = 1'b1;
      rr    = '0;
      fl    = '0;
      ures  = 0;
      sres  = 0;
      if (op == OP_DADD || op == OP_DSUB) begin
         ua = {32'h0, a};
         ub = {32'h0, b};
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         if (op == OP_DADD) begin
            ures = ua + ub;
            sres = sa + sb;
         end else begin
            ures = ua + (64'h0000_0000_FFFF_FFFF - ub) + 64'd1;
            sres = sa - sb;
         end
         ov = (sres > MAX32) || (sres < MIN32);
         rr = ures[31:0];
         fl = {ures[32], ~ov, (ures[31:0] == 32'h0)};
      end else if (op == OP_AND || op == OP_OR || op == OP_XOR) begin
         arith = 1'b0;
         if (op == OP_AND)     rr = {16'h0, a[15:0] & b[15:0]};
         else if (op == OP_OR) rr = {16'h0, a[15:0] | b[15:0]};
         else                  rr = {16'h0, a[15:0] ^ b[15:0]};
         fl = {cfg, 1'b1, (rr == 32'h0)};
      end else begin
         ua = {48'h0, a[15:0]};
         ub = {48'h0, b[15:0]};
         sa = longint'($signed(a[15:0]));
         sb = longint'($signed(b[15:0]));
         if (op == OP_ADD) begin
            ures = ua + ub;
            sres = sa + sb;
         end else if (op == OP_SUB) begin
            ures = ua + (64'd65535 - ub) + 64'd1;
            sres = sa - sb;
         end else begin
            ures = ua + ub + {63'h0, cin};
            sres = sa + sb + {63'h0, cin};
         end
         ov = (sres > 64'sd32767) || (sres < -64'sd32768);
         rr = {16'h0, ures[15:0]};
         fl = {ures[16], ~ov, (ures[15:0] == 16'h0)};
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      cf_ref = '0;
      cf_g   = 1'b0;
   endtask

   // Drives one request from an idle block and captures what the DUT shows.
   task automatic run_op(input int rq, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int gl, output int dl, output logic [31:0] rr, output logic [2:0] fl,
                         output logic [3:0] ctl, output logic cin_hi, output logic extra_done);
      gl = -1; dl = -1; rr = '0; fl = '0; ctl = '0; cin_hi = 1'b0; extra_done = 1'b0;
      @(negedge clk);
      if (rq == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      else         begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      for (int n = 1; n <= 8 && gl < 0; n++) begin
         @(posedge clk); #1;
         if ((rq == 0) ? gnt0 : gnt1) begin
            gl  = n;
            ctl = {ea_k, ea_l, ea_add, ea_cin};
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      if (gl < 0) return;
      for (int m = 1; m <= 8 && dl < 0; m++) begin
         @(posedge clk); #1;
         if (m == 1) cin_hi = ea_cin;
         if ((rq == 0) ? done0 : done1) begin
            dl = m + 1;
            rr = r;
            fl = {cf, vf_n, zf};
         end
      end
      @(posedge clk); #1;
      extra_done = done0 | done1;
   endtask

   task automatic do_op(input int rq, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [43:0] obs, output logic [43:0] exp,
                        output logic [3:0] ctl, output logic cin_hi);
      int          gl, dl;
      logic [31:0] rr, er;
      logic [2:0]  fl, ef;
      logic        xd, ar;
      ref_op(op, a, b, cf_ref[rq], cf_g, er, ef, ar);
      run_op(rq, op, a, b, gl, dl, rr, fl, ctl, cin_hi, xd);
      obs = {rr, fl, gl[3:0], dl[3:0], xd};
      exp = {er, ef, 4'd1, (op == OP_DADD || op == OP_DSUB) ? 4'd3 : 4'd2, 1'b0};
      if (ar) begin
         cf_ref[rq] = ef[2];
         cf_g       = ef[2];
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
         failures++; $display("FAIL reset_pulses got=%b want=0000", {gnt0, gnt1, done0, done1});
      end
      checks++;
      if ({r, cf, vf_n, zf} !== {32'h0, 3'b010}) begin
         failures++; $display("FAIL reset_result got r=%h f=%b want r=0 f=010", r, {cf, vf_n, zf});
      end
      checks++;
      if ({ea_x, ea_y, ea_k, ea_l, ea_add, ea_cin} !== 36'h0) begin
         failures++; $display("FAIL reset_core got x=%h y=%h c=%b want 0", ea_x, ea_y, {ea_k, ea_l, ea_add, ea_cin});
      end
   endtask

   task automatic test_single_add();
      logic [43:0] obs, exp;
      logic [3:0]  ctl;
      logic        ch;
      do_op(0, OP_ADD, 32'h0000_7FFF, 32'h0000_0001, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL single_add got=%h want=%h", obs, exp); end
      checks++;
      if (ctl !== 4'b1110) begin failures++; $display("FAIL single_add_ctl got=%b want=1110", ctl); end
   endtask

   task automatic test_dsub();
      logic [43:0] obs, exp;
      logic [3:0]  ctl;
      logic        ch;
      do_op(1, OP_DSUB, 32'h0001_0000, 32'h0000_0001, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL dsub got=%h want=%h", obs, exp); end
      checks++;
      if ({ctl, ch} !== 5'b1111_0) begin failures++; $display("FAIL dsub_cin got=%b want=11110", {ctl, ch}); end
   endtask

   task automatic test_round_robin();
      int         ng, nfg, nd, last_done;
      logic [3:0] ord, ford;
      apply_reset();
      @(negedge clk);
      op0 = OP_ADD; op1 = OP_ADD;
      a0 = 32'h1; b0 = 32'h1; a1 = 32'h1; b1 = 32'h1;
      req0 = 1'b1; req1 = 1'b1;
      ng = 0; nfg = 0; nd = 0; last_done = -1; ord = '0; ford = '0;
      for (int cyc = 1; cyc <= 30 && nd < 4; cyc++) begin
         @(posedge clk); #1;
         if ((gnt0 || gnt1) && ng < 4) begin
            ord[ng] = gnt1;
            ng++;
            if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
         end
         if ((f_gnt0 || f_gnt1) && nfg < 4) begin
            ford[nfg] = f_gnt1;
            nfg++;
         end
         if (done0 || done1) begin
            checks++;
            if (r !== 32'h2 || (last_done >= 0 && cyc - last_done != 2)) begin
               failures++; $display("FAIL rr_done got r=%h gap=%0d want r=2 gap=2", r, cyc - last_done);
            end
            last_done = cyc;
            nd++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if ({ng, ord} !== {32'd4, 4'b1010}) begin
         failures++; $display("FAIL rr_order got n=%0d order=%b want n=4 order=1010", ng, ord);
      end
      checks++;
      if ({nfg, ford} !== {32'd4, 4'b0000}) begin
         failures++; $display("FAIL fixed_order got n=%0d order=%b want n=4 order=0000", nfg, ford);
      end
      checks++;
      if (nd !== 4) begin failures++; $display("FAIL rr_done_count got=%0d want=4", nd); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_addc_chain();
      logic [43:0] obs, exp;
      logic [3:0]  ctl;
      logic        ch;
      do_op(0, OP_ADD, 32'h0000_FFFF, 32'h0000_0001, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL addc_seed got=%h want=%h", obs, exp); end
      do_op(1, OP_ADDC, 32'h0, 32'h0, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL addc_req1 got=%h want=%h", obs, exp); end
      do_op(0, OP_ADDC, 32'h0, 32'h0, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp || obs[43:12] !== 32'h1) begin
         failures++; $display("FAIL addc_req0 got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_logic();
      logic [43:0] obs, exp;
      logic [3:0]  ctl;
      logic        ch;
      do_op(0, OP_ADD, 32'h0000_FFFF, 32'h0000_0001, obs, exp, ctl, ch);
      do_op(0, OP_XOR, 32'h0000_AAAA, 32'h0000_FFFF, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp || ctl !== 4'b1100) begin
         failures++; $display("FAIL logic_xor got=%h/%b want=%h/1100", obs, ctl, exp);
      end
      do_op(1, OP_AND, 32'h0000_F0F0, 32'h0000_0F0F, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp || ctl !== 4'b0000) begin
         failures++; $display("FAIL logic_and got=%h/%b want=%h/0000", obs, ctl, exp);
      end
      do_op(0, OP_OR, 32'h1234_00F0, 32'hABCD_0F00, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp || ctl !== 4'b0100) begin
         failures++; $display("FAIL logic_or got=%h/%b want=%h/0100", obs, ctl, exp);
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] er;
      logic [2:0]  ef;
      logic        ar;
      int          g0, d1;
      @(negedge clk);
      op1 = OP_DADD; a1 = $urandom; b1 = $urandom; req1 = 1'b1;
      ref_op(OP_DADD, a1, b1, cf_ref[1], cf_g, er, ef, ar);
      for (int n = 0; n < 8 && !gnt1; n++) begin @(posedge clk); #1; end
      checks++;
      if (gnt1 !== 1'b1) begin failures++; $display("FAIL busy_gnt1 got=%b want=1", gnt1); end
      req1 = 1'b0;
      op0 = OP_ADD; a0 = 32'h1; b0 = 32'h1; req0 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0;
      g0 = 0; d1 = 0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (gnt0) g0++;
         if (done1) begin
            d1++;
            checks++;
            if ({r, cf, vf_n, zf} !== {er, ef}) begin
               failures++; $display("FAIL busy_dadd got=%h want=%h", {r, cf, vf_n, zf}, {er, ef});
            end
         end
      end
      checks++;
      if ({g0, d1} !== {32'd0, 32'd1}) begin
         failures++; $display("FAIL busy_ignore got gnt0=%0d done1=%0d want 0 1", g0, d1);
      end
      cf_ref[1] = ef[2];
      cf_g      = ef[2];
   endtask

   task automatic test_reset_mid_dadd();
      logic [43:0] obs, exp;
      logic [3:0]  ctl;
      logic        ch;
      int          dn;
      do_op(0, OP_ADD, 32'h0000_FFFF, 32'h0000_0001, obs, exp, ctl, ch);
      @(negedge clk);
      op0 = OP_DADD; a0 = $urandom; b0 = $urandom; req0 = 1'b1;
      for (int n = 0; n < 8 && !gnt0; n++) begin @(posedge clk); #1; end
      req0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({done0, done1, gnt0, gnt1, r, cf, vf_n, zf} !== {4'b0000, 32'h0, 3'b010}) begin
         failures++;
         $display("FAIL reset_mid got pulses=%b r=%h f=%b want 0000 0 010",
                  {done0, done1, gnt0, gnt1}, r, {cf, vf_n, zf});
      end
      checks++;
      if ({ea_k, ea_l, ea_add, ea_cin} !== 4'b0000) begin
         failures++; $display("FAIL reset_mid_core got=%b want=0000", {ea_k, ea_l, ea_add, ea_cin});
      end
      rst    = 1'b0;
      cf_ref = '0;
      cf_g   = 1'b0;
      dn = 0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         if (done0 || done1) dn++;
      end
      checks++;
      if (dn !== 0) begin failures++; $display("FAIL reset_mid_nodone got=%0d want=0", dn); end
      do_op(0, OP_ADDC, 32'h0, 32'h0, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_cf0_clear got=%h want=%h", obs, exp); end
      do_op(0, OP_ADD, 32'h0000_1234, 32'h0000_4321, obs, exp, ctl, ch);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_after_add got=%h want=%h", obs, exp); end
   endtask

   task automatic test_random();
      logic [43:0] obs, exp;
      logic [3:0]  ctl;
      logic        ch;
      logic [31:0] a, b;
      logic [2:0]  op;
      int          rq;
      for (int i = 0; i < 40; i++) begin
         rq = int'($urandom_range(1, 0));
         op = 3'($urandom_range(7, 0));
         a  = $urandom;
         b  = ($urandom_range(3, 0) == 0) ? a : $urandom;
         do_op(rq, op, a, b, obs, exp, ctl, ch);
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL random[%0d] op=%0d rq=%0d got=%h want=%h", i, op, rq, obs, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      cf_ref = '0;
      cf_g   = 1'b0;
      test_reset();
      test_single_add();
      test_dsub();
      test_round_robin();
      test_addc_chain();
      test_logic();
      test_busy_ignore();
      test_reset_mid_dadd();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
